// File: rtl/manch_rx_ctrl.sv
// Frame-level receive controller for the Manchester RF decoder: sync-word hunt,
// length byte, payload bytes, with start/done/error pulses toward the host.
module manch_rx_ctrl #(
  parameter logic [15:0] SYNC_WORD = 16'hA55A,
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic       clk2x,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       dec_dout,
  input  logic       dec_error,
  input  logic       bit_stb,
  output logic       dec_enable,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [7:0] frame_len,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [7:0]       MAX_LEN_C = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HUNT = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [15:0]      hunt_sr_r;
  logic [4:0]       hunt_cnt_r;
  logic [7:0]       byte_sr_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       byte_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;

  logic       dec_enable_r;
  logic [7:0] byte_data_r;
  logic       byte_valid_r;
  logic [7:0] frame_len_r;
  logic       frame_start_r;
  logic       frame_done_r;
  logic       frame_err_r;
  logic       busy_r;

  logic        good_stb_s;
  logic        bad_stb_s;
  logic [15:0] hunt_shift_s;
  logic [4:0]  hunt_cnt_inc_s;
  logic        sync_hit_s;
  logic [7:0]  byte_shift_s;
  logic        byte_end_s;
  logic        tmo_hit_s;
  logic        len_bad_s;
  logic        last_byte_s;
  logic        in_frame_r_s;
  logic        in_frame_next_s;
  logic        byte_valid_s;
  logic        len_ok_s;

  assign good_stb_s     = bit_stb & ~dec_error;
  assign bad_stb_s      = bit_stb & dec_error;
  assign hunt_shift_s   = {hunt_sr_r[14:0], dec_dout};
  assign hunt_cnt_inc_s = (hunt_cnt_r == 5'd16) ? 5'd16 : hunt_cnt_r + 5'd1;
  // The match is judged on the value the current strobe is shifting in.
  assign sync_hit_s     = good_stb_s && (hunt_cnt_inc_s == 5'd16) && (hunt_shift_s == SYNC_WORD);
  assign byte_shift_s   = {byte_sr_r[6:0], dec_dout};
  assign byte_end_s     = good_stb_s && (bit_cnt_r == 3'd7);
  assign tmo_hit_s      = !bit_stb && (tmo_cnt_r == TMO_LAST);
  assign len_bad_s      = (byte_shift_s == 8'd0) || (byte_shift_s > MAX_LEN_C);
  assign last_byte_s    = (byte_cnt_r == 8'd1);
  assign in_frame_r_s   = (state_r == ST_LEN) || (state_r == ST_DATA);
  assign in_frame_next_s = (state_s == ST_LEN) || (state_s == ST_DATA);
  assign byte_valid_s   = (state_r == ST_DATA) && byte_end_s && rx_en;
  assign len_ok_s       = (state_r == ST_LEN) && byte_end_s && rx_en && !len_bad_s;

  // Next-state decode for the frame FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_en) state_s = ST_HUNT;
        else       state_s = ST_IDLE;
      end
      ST_HUNT: begin
        if (!rx_en)          state_s = ST_IDLE;
        else if (sync_hit_s) state_s = ST_LEN;
        else                 state_s = ST_HUNT;
      end
      ST_LEN: begin
        if (!rx_en || bad_stb_s || tmo_hit_s) state_s = ST_ERR;
        else if (byte_end_s)                  state_s = len_bad_s ? ST_ERR : ST_DATA;
        else                                  state_s = ST_LEN;
      end
      ST_DATA: begin
        if (!rx_en || bad_stb_s || tmo_hit_s) state_s = ST_ERR;
        else if (byte_end_s && last_byte_s)   state_s = ST_DONE;
        else                                  state_s = ST_DATA;
      end
      ST_DONE: begin
        if (rx_en) state_s = ST_HUNT;
        else       state_s = ST_IDLE;
      end
      ST_ERR: begin
        if (rx_en) state_s = ST_HUNT;
        else       state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and registered status outputs, all decoded from the next state.
  always_ff @(posedge clk2x) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      dec_enable_r  <= 1'b0;
      busy_r        <= 1'b0;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_err_r   <= 1'b0;
      byte_valid_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      dec_enable_r  <= (state_s != ST_IDLE);
      busy_r        <= in_frame_next_s;
      frame_start_r <= (state_r == ST_HUNT) && (state_s == ST_LEN);
      frame_done_r  <= (state_s == ST_DONE);
      frame_err_r   <= (state_s == ST_ERR);
      byte_valid_r  <= byte_valid_s;
    end
  end

  // Sync hunt shifter and valid-bit counter; cleared whenever not hunting.
  always_ff @(posedge clk2x) begin
    if (rst) begin
      hunt_sr_r  <= 16'd0;
      hunt_cnt_r <= 5'd0;
    end else if (state_r == ST_HUNT) begin
      if (bad_stb_s) begin
        hunt_cnt_r <= 5'd0;
      end else if (good_stb_s) begin
        hunt_sr_r  <= hunt_shift_s;
        hunt_cnt_r <= hunt_cnt_inc_s;
      end
    end else begin
      hunt_sr_r  <= 16'd0;
      hunt_cnt_r <= 5'd0;
    end
  end

  // Byte assembly, bit/byte counters, inter-strobe timeout and latched byte outputs.
  always_ff @(posedge clk2x) begin
    if (rst) begin
      byte_sr_r   <= 8'd0;
      bit_cnt_r   <= 3'd0;
      byte_cnt_r  <= 8'd0;
      tmo_cnt_r   <= '0;
      byte_data_r <= 8'd0;
      frame_len_r <= 8'd0;
    end else begin
      if (in_frame_r_s && in_frame_next_s) begin
        if (bit_stb) begin
          tmo_cnt_r <= '0;
        end else begin
          tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
        if (good_stb_s) begin
          byte_sr_r <= byte_shift_s;
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
      end else begin
        // Any partial byte is dropped on entry, exit or abort.
        byte_sr_r <= 8'd0;
        bit_cnt_r <= 3'd0;
        tmo_cnt_r <= '0;
      end
      if ((state_r == ST_LEN) && byte_end_s && rx_en) begin
        byte_data_r <= byte_shift_s;
      end else if (byte_valid_s) begin
        byte_data_r <= byte_shift_s;
      end
      if (len_ok_s) begin
        frame_len_r <= byte_shift_s;
        byte_cnt_r  <= byte_shift_s;
      end else if (byte_valid_s) begin
        byte_cnt_r  <= byte_cnt_r - 8'd1;
      end
    end
  end

  assign dec_enable  = dec_enable_r;
  assign byte_data   = byte_data_r;
  assign byte_valid  = byte_valid_r;
  assign frame_len   = frame_len_r;
  assign frame_start = frame_start_r;
  assign frame_done  = frame_done_r;
  assign frame_err   = frame_err_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_manch_rx_ctrl.sv
// Directed bench for manch_rx_ctrl: sync hunt, length/payload framing, aborts, timeout, reset.
module tb_manch_rx_ctrl;

  logic       clk2x     = 1'b0;
  logic       rst       = 1'b1;
  logic       rx_en     = 1'b0;
  logic       dec_dout  = 1'b0;
  logic       dec_error = 1'b0;
  logic       bit_stb   = 1'b0;
  logic       dec_enable;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [7:0] frame_len;
  logic       frame_start;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;
  int n_start = 0;
  int n_done  = 0;
  int n_err   = 0;
  int b_start, b_done, b_err, b_bytes;
  logic [7:0] bytes[$];

  always #5 clk2x = ~clk2x;

  manch_rx_ctrl dut (
    .clk2x       (clk2x),
    .rst         (rst),
    .rx_en       (rx_en),
    .dec_dout    (dec_dout),
    .dec_error   (dec_error),
    .bit_stb     (bit_stb),
    .dec_enable  (dec_enable),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .frame_len   (frame_len),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk2x) begin
    if (frame_start) n_start = n_start + 1;
    if (frame_done)  n_done  = n_done + 1;
    if (frame_err)   n_err   = n_err + 1;
    if (byte_valid)  bytes.push_back(byte_data);
  end

  task automatic tick();
    @(posedge clk2x);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_mis = n_mis + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic b, input logic e);
    bit_stb   = 1'b1;
    dec_dout  = b;
    dec_error = e;
    tick();
    bit_stb   = 1'b0;
    dec_dout  = 1'b0;
    dec_error = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      strobe(v[i], 1'b0);
      tick();
    end
  endtask

  task automatic snap();
    b_start = n_start;
    b_done  = n_done;
    b_err   = n_err;
    b_bytes = bytes.size();
  endtask

  task automatic frame_head(input logic [7:0] len);
    send_bits(32'h0000A55A, 16);
    send_bits({24'd0, len}, 8);
  endtask

  initial begin
    repeat (3) tick();
    check("reset_outs", {22'd0, dec_enable, byte_data, byte_valid, frame_len, frame_start,
                         frame_done, frame_err, busy}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_dec_enable", {31'd0, dec_enable}, 32'd0);

    // Test 1: good frame of 3 bytes, exact start/done timing.
    snap();
    rx_en = 1'b1;
    tick();
    check("hunt_dec_enable", {31'd0, dec_enable}, 32'd1);
    send_bits(32'h000052AD, 15);
    check("t1_no_early_start", n_start - b_start, 32'd0);
    strobe(1'b0, 1'b0);
    check("t1_frame_start", {31'd0, frame_start}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t1_start_pulse_1cyc", {31'd0, frame_start}, 32'd0);
    send_bits(32'h03, 8);
    check("t1_frame_len", {24'd0, frame_len}, 32'h03);
    check("t1_len_on_byte_data", {24'd0, byte_data}, 32'h03);
    send_bits(32'h11, 8);
    send_bits(32'h22, 8);
    send_bits(32'h19, 7);
    strobe(1'b1, 1'b0);
    check("t1_last_valid", {31'd0, byte_valid}, 32'd1);
    check("t1_last_data", {24'd0, byte_data}, 32'h33);
    check("t1_frame_done", {31'd0, frame_done}, 32'd1);
    check("t1_busy_off", {31'd0, busy}, 32'd0);
    tick();
    check("t1_done_pulse_1cyc", {30'd0, frame_done, byte_valid}, 32'd0);
    check("t1_data_held", {24'd0, byte_data}, 32'h33);
    check("t1_nbytes", bytes.size() - b_bytes, 32'd3);
    check("t1_b0", {24'd0, bytes[b_bytes]}, 32'h11);
    check("t1_b1", {24'd0, bytes[b_bytes+1]}, 32'h22);
    check("t1_b2", {24'd0, bytes[b_bytes+2]}, 32'h33);
    check("t1_counts", {(n_start - b_start), (n_done - b_done), (n_err - b_err)} , {32'd1, 32'd1, 32'd0});

    // Test 2: corrupted sync ignored, correct sync accepted.
    snap();
    send_bits(32'h0000A45A, 16);
    check("t2_bad_sync", n_start - b_start, 32'd0);
    send_bits(32'h0000A55A, 16);
    check("t2_good_sync", n_start - b_start, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd1);

    // Test 3: length 0 and MAX_LEN+1 are rejected.
    send_bits(32'h00, 8);
    check("t3_len0_err", n_err - b_err, 32'd1);
    check("t3_len0_hunt", {30'd0, dec_enable, busy}, 32'b10);
    check("t3_len_hold", {24'd0, frame_len}, 32'h03);
    frame_head(8'd33);
    check("t3_len33_err", n_err - b_err, 32'd2);
    check("t3_no_bytes", bytes.size() - b_bytes, 32'd0);
    check("t3_no_done", n_done - b_done, 32'd0);

    // Boundaries: length 1 and length MAX_LEN are legal.
    snap();
    frame_head(8'd1);
    send_bits(32'h5A, 8);
    check("len1_done", n_done - b_done, 32'd1);
    check("len1_byte", {24'd0, bytes[b_bytes]}, 32'h5A);
    snap();
    frame_head(8'd32);
    for (int i = 0; i < 32; i++) send_bits(32'(i * 5 + 3), 8);
    check("len32_done", n_done - b_done, 32'd1);
    check("len32_nbytes", bytes.size() - b_bytes, 32'd32);
    check("len32_last", {24'd0, bytes[b_bytes+31]}, 32'h9E);
    check("len32_frame_len", {24'd0, frame_len}, 32'h20);
    check("len32_err", n_err - b_err, 32'd0);

    // Test 4: decoder error on bit 5 of payload byte 2.
    snap();
    frame_head(8'd2);
    send_bits(32'hAB, 8);
    send_bits(32'hC, 4);
    strobe(1'b1, 1'b1);
    check("t4_err_pulse", {30'd0, frame_err, byte_valid}, 32'b10);
    tick();
    check("t4_back_hunt", {29'd0, frame_err, dec_enable, busy}, 32'b010);
    check("t4_nbytes", bytes.size() - b_bytes, 32'd1);
    check("t4_byte", {24'd0, bytes[b_bytes]}, 32'hAB);
    check("t4_counts", {(n_err - b_err), (n_done - b_done)}, {32'd1, 32'd0});

    // Test 5: strobes stop in DATA; error after exactly 64 strobe-free cycles.
    snap();
    frame_head(8'd2);
    send_bits(32'h2E, 7);
    strobe(1'b0, 1'b0);
    check("t5_byte_valid", {24'd0, byte_data}, 32'h5C);
    repeat (63) tick();
    check("t5_not_yet", {30'd0, frame_err, busy}, 32'b01);
    tick();
    check("t5_timeout_err", {30'd0, frame_err, busy}, 32'b10);
    tick();
    check("t5_err_count", n_err - b_err, 32'd1);

    // Test 6a: rx_en dropped mid-payload.
    snap();
    frame_head(8'd4);
    send_bits(32'h01, 8);
    send_bits(32'h5, 3);
    rx_en = 1'b0;
    tick();
    check("t6_err", {30'd0, frame_err, dec_enable}, 32'b11);
    tick();
    check("t6_idle", {29'd0, frame_err, dec_enable, busy}, 32'd0);
    check("t6_counts", {(n_err - b_err), (n_done - b_done)}, {32'd1, 32'd0});

    // Test 6b: reset mid-frame.
    rx_en = 1'b1;
    tick();
    snap();
    frame_head(8'd2);
    send_bits(32'h77, 8);
    check("t6_pre_rst", {16'd0, byte_data, frame_len}, 32'h7702);
    send_bits(32'h5, 3);
    rst = 1'b1;
    tick();
    check("t6_rst_outs", {22'd0, dec_enable, byte_data, byte_valid, frame_len, frame_start,
                          frame_done, frame_err, busy}, 32'd0);
    rst = 1'b0;
    tick();
    check("t6_rst_release", {30'd0, dec_enable, busy}, 32'b10);
    check("t6_rst_no_pulse", {(n_err - b_err), (n_done - b_done)}, {32'd0, 32'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
